// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// Each write takes three cycles: grant, capture+ack, release.
module shared_reg_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int OWN_W = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] data_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       ack_o,
  output logic [WIDTH-1:0]       q_o,
  output logic [OWN_W-1:0]       owner_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

  localparam logic [N_REQ-1:0] ONE  = N_REQ'(1);
  localparam logic [OWN_W-1:0] LAST = OWN_W'(N_REQ - 1);

  state_t           state_q, state_d;
  logic [OWN_W-1:0] ptr_q, ptr_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic             busy_q, busy_d;
  logic             sel_found;
  logic [OWN_W-1:0] sel_idx;
  int               idx;

  // Walk from the farthest candidate back to ptr so the nearest requester wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_i[idx]) begin
        sel_found = 1'b1;
        sel_idx   = OWN_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    reg_d   = reg_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        ack_d = '0;
        if (sel_found) begin
          gnt_d   = ONE << sel_idx;
          owner_d = sel_idx;
          busy_d  = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Commit point: a request withdrawn after the grant still completes.
        reg_d   = data_i[int'(owner_q)*WIDTH +: WIDTH];
        ack_d   = ONE << owner_q;
        state_d = ACK;
      end
      ACK: begin
        gnt_d   = '0;
        ack_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = (owner_q == LAST) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        ack_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      reg_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      reg_q   <= reg_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign ack_o   = ack_q;
  assign q_o     = reg_q;
  assign owner_o = owner_q;
  assign busy_o  = busy_q;

endmodule
